wb_rr_arbiter: RTL and testbench

Two-master Wishbone round-robin arbiter with a bus watchdog. It sits between the LM32 instruction and data ports and a single shared Wishbone slave port, such as the interconnect's master input or a dedicated memory. It grants the bus to one master at a time and holds the grant for the whole cycle, so bursts and locked sequences are not split. It also terminates any transfer that a slave never acknowledges.

---
 rtl/wb_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Two-master Wishbone round-robin arbiter with a bus watchdog.
//               It grants one master at a time and holds the grant for the
//               whole bus cycle, so bursts and locked sequences stay intact.
//               Strobes that the slave never terminates are ended with a
//               forced error.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   to_width        width of the watchdog counter
//   timeout_cycles  unacknowledged strobe cycles tolerated before a forced
//                   error; 0 disables the watchdog; must fit in to_width bits
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   m0_* / m1_*           master bus inputs (cyc, stb, we, adr, dat, sel);
//                         read data plus ack/err/rty back to each master
//   s_*                   shared slave port: controls out, data/terminations in
//   gnt_o                 one-hot registered grant, bit0 = m0, 00 when idle
//   timeout_o             one-cycle pulse following a watchdog expiry
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
  parameter int to_width       = 8,
  parameter int timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // master 0 (instruction port)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  // master 1 (data port)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  // shared slave port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  // status
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  // State encoding equals the one-hot grant, so gnt_o is a direct register
  // read with no decode glitches.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  localparam logic [to_width-1:0] c_timeout = to_width'(timeout_cycles);
  localparam bit                  c_wd_en   = (timeout_cycles != 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;        // most recently granted master
  logic [to_width-1:0] r_count;
  logic [to_width-1:0] w_count_nxt;
  logic                r_timeout;

  logic                w_g0;
  logic                w_g1;
  logic                w_strobe;
  logic                w_term;
  logic                w_expire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_timeout <= w_expire;
      // Remember who just finished so the other master wins the next tie.
      if (r_state == ST_G0 && !m0_cyc_i) begin
        r_last <= 1'b0;
      end else if (r_state == ST_G1 && !m1_cyc_i) begin
        r_last <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last ? ST_G0 : ST_G1;
        end else if (m0_cyc_i) begin
          w_state_nxt = ST_G0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_G1;
        end
      end
      // Grant is held for the whole cycle; on release hand straight over to
      // a waiting master so there is no dead cycle.
      ST_G0: begin
        if (!m0_cyc_i) begin
          w_state_nxt = m1_cyc_i ? ST_G1 : ST_IDLE;
        end
      end
      ST_G1: begin
        if (!m1_cyc_i) begin
          w_state_nxt = m0_cyc_i ? ST_G0 : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_g0 = (r_state == ST_G0);
  assign w_g1 = (r_state == ST_G1);

  // --------------------------------------------------------------------------
  // Request-side mux: combinational routing from the granted master
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_g0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_g1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  assign w_strobe = s_cyc_o & s_stb_o;
  assign w_term   = s_ack_i | s_err_i | s_rty_i;
  // A real slave termination in the expiry cycle wins over the forced error.
  assign w_expire = c_wd_en && w_strobe && !w_term && (r_count == c_timeout);

  always_comb begin
    w_count_nxt = r_count + 1'b1;
    if (!c_wd_en || !w_strobe || w_term || w_expire ||
        (w_state_nxt != r_state)) begin
      w_count_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Response-side routing: data broadcast, terminations to the grantee only
  // --------------------------------------------------------------------------
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = w_g0 & s_ack_i;
  assign m0_err_o = w_g0 & (s_err_i | w_expire);
  assign m0_rty_o = w_g0 & s_rty_i;

  assign m1_ack_o = w_g1 & s_ack_i;
  assign m1_err_o = w_g1 & (s_err_i | w_expire);
  assign m1_rty_o = w_g1 & s_rty_i;

  assign gnt_o     = r_state;
  assign timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Self-checking bench for wb_rr_arbiter. Stimulus queues the
//               expected bus picture for each cycle it cares about; a monitor
//               on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

  localparam int c_to_width = 8;
  localparam int c_timeout  = 4;
  localparam logic [31:0] c_dat  = 32'hCAFE_0001;
  localparam logic [3:0]  c_sel0 = 4'h3;
  localparam logic [3:0]  c_sel1 = 4'hC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  wb_rr_arbiter #(
    .to_width       (c_to_width),
    .timeout_cycles (c_timeout)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_adr_i  (m0_adr_i),
    .m0_dat_i  (m0_dat_i),
    .m0_sel_i  (m0_sel_i),
    .m0_dat_o  (m0_dat_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m0_rty_o  (m0_rty_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_adr_i  (m1_adr_i),
    .m1_dat_i  (m1_dat_i),
    .m1_sel_i  (m1_sel_i),
    .m1_dat_o  (m1_dat_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .m1_rty_o  (m1_rty_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  gnt;
    logic        s_cyc;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        ack0, ack1, err0, err1, to;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic ex(input string nm, input logic [1:0] g, input logic sc,
                    input logic [31:0] a, input logic [3:0] sl,
                    input logic a0, input logic a1, input logic e0,
                    input logic e1, input logic t);
    exp_t e;
    e.cyc = cyc_n; e.gnt = g; e.s_cyc = sc; e.adr = a; e.sel = sl;
    e.ack0 = a0; e.ack1 = a1; e.err0 = e0; e.err1 = e1; e.to = t;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the DUT against every expectation tagged for this cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc_n) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (int'(e.cyc) < cyc_n) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                 nm, e.cyc, cyc_n);
      end else if (gnt_o !== e.gnt || s_cyc_o !== e.s_cyc ||
                   s_adr_o !== e.adr || s_sel_o !== e.sel ||
                   m0_ack_o !== e.ack0 || m1_ack_o !== e.ack1 ||
                   m0_err_o !== e.err0 || m1_err_o !== e.err1 ||
                   timeout_o !== e.to || m0_dat_o !== c_dat ||
                   m1_dat_o !== c_dat) begin
        errors++;
        $display("FAIL %s cyc=%0d: got gnt=%b scyc=%b adr=%h sel=%h ack=%b%b err=%b%b to=%b dat=%h/%h; want gnt=%b scyc=%b adr=%h sel=%h ack=%b%b err=%b%b to=%b dat=%h",
                 nm, cyc_n, gnt_o, s_cyc_o, s_adr_o, s_sel_o, m0_ack_o, m1_ack_o,
                 m0_err_o, m1_err_o, timeout_o, m0_dat_o, m1_dat_o,
                 e.gnt, e.s_cyc, e.adr, e.sel, e.ack0, e.ack1, e.err0, e.err1,
                 e.to, c_dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(input logic c, input logic [31:0] a);
    m0_cyc_i = c; m0_stb_i = c; m0_adr_i = a;
  endtask

  task automatic m1_set(input logic c, input logic [31:0] a);
    m1_cyc_i = c; m1_stb_i = c; m1_adr_i = a;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_set(1'b0, 32'h0);
    m1_set(1'b0, 32'h0);
    s_ack_i = 1'b0;
    tick();
    ex("reset_state", 2'b00, 1'b0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset_n  = 1'b0;
    m0_we_i  = 1'b0; m0_dat_i = 32'h1111_0000; m0_sel_i = c_sel0;
    m1_we_i  = 1'b1; m1_dat_i = 32'h2222_0000; m1_sel_i = c_sel1;
    m0_set(1'b0, 32'h0);
    m1_set(1'b0, 32'h0);
    s_dat_i = c_dat; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // ---- single master request and ack routing ----
    do_reset();
    tick();
    m0_set(1'b1, 32'h0000_0100);
    ex("a_req_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    tick();
    ex("a_grant", 2'b01, 1, 32'h100, c_sel0, 0, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b1;
    ex("a_ack", 2'b01, 1, 32'h100, c_sel0, 1, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b0; m0_set(1'b0, 32'h100);
    ex("a_drop", 2'b01, 0, 32'h100, c_sel0, 0, 0, 0, 0, 0);
    tick();
    ex("a_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);

    // ---- simultaneous requests, alternation ----
    do_reset();
    m0_set(1'b1, 32'hA0); m1_set(1'b1, 32'hB0);
    ex("b_req_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b1;
    ex("b_g0_first", 2'b01, 1, 32'hA0, c_sel0, 1, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b0; m0_set(1'b0, 32'hA0);
    ex("b_m0_drop", 2'b01, 0, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b1; m0_set(1'b1, 32'hA0);
    ex("b_g1_handoff", 2'b10, 1, 32'hB0, c_sel1, 0, 1, 0, 0, 0);
    tick();
    s_ack_i = 1'b0; m1_set(1'b0, 32'hB0);
    ex("b_m1_drop", 2'b10, 0, 32'hB0, c_sel1, 0, 0, 0, 0, 0);
    tick();
    ex("b_g0_again", 2'b01, 1, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    m0_set(1'b0, 32'hA0);
    ex("b_m0_drop2", 2'b01, 0, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    ex("b_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);

    // ---- m1 burst holds grant while m0 waits ----
    tick();
    m1_set(1'b1, 32'hC0);
    ex("c_req_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    tick();
    m0_set(1'b1, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1;
      ex("c_burst_beat", 2'b10, 1, 32'hC0, c_sel1, 0, 1, 0, 0, 0);
      tick();
    end
    s_ack_i = 1'b0; m1_set(1'b0, 32'hC0);
    ex("c_m1_drop", 2'b10, 0, 32'hC0, c_sel1, 0, 0, 0, 0, 0);
    tick();
    ex("c_g0_after", 2'b01, 1, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    m0_set(1'b0, 32'hA0);
    ex("c_m0_drop", 2'b01, 0, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    ex("c_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);

    // ---- watchdog expiry, T = 4 ----
    tick();
    m0_set(1'b1, 32'hD0);
    ex("d_req_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      ex("d_wait", 2'b01, 1, 32'hD0, c_sel0, 0, 0, 0, 0, 0);
    end
    tick();
    ex("d_expire_err", 2'b01, 1, 32'hD0, c_sel0, 0, 0, 1, 0, 0);
    tick();
    ex("d_timeout_pulse", 2'b01, 1, 32'hD0, c_sel0, 0, 0, 0, 0, 1);
    tick();
    m0_set(1'b0, 32'hD0);
    ex("d_pulse_done", 2'b01, 0, 32'hD0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    ex("d_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);

    // ---- slave ack in the expiry cycle wins ----
    tick();
    m0_set(1'b1, 32'hE0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      ex("e_wait", 2'b01, 1, 32'hE0, c_sel0, 0, 0, 0, 0, 0);
    end
    tick();
    s_ack_i = 1'b1;
    ex("e_ack_wins", 2'b01, 1, 32'hE0, c_sel0, 1, 0, 0, 0, 0);
    tick();
    s_ack_i = 1'b0; m0_set(1'b0, 32'hE0);
    ex("e_no_pulse", 2'b01, 0, 32'hE0, c_sel0, 0, 0, 0, 0, 0);
    tick();
    ex("e_idle", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);

    // ---- asynchronous reset mid-transfer in G1 ----
    m1_set(1'b1, 32'hF0);
    tick();
    m0_set(1'b1, 32'hA0);
    ex("f_g1", 2'b10, 1, 32'hF0, c_sel1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL f_async_reset: got scyc=%b gnt=%b; want scyc=0 gnt=00",
               s_cyc_o, gnt_o);
    end
    tick();
    ex("f_in_reset", 2'b00, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    ex("f_m0_first", 2'b01, 1, 32'hA0, c_sel0, 0, 0, 0, 0, 0);
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
